apb_reg_arbiter: RTL and testbench

Arbitrating APB master that shares the 8-register APB slave (one-hot `select_reg` map, A..H = 8'h01..8'h80) between NUM_REQ on-chip requesters. It accepts simple valid/done requests and grants them round-robin. It runs each granted request as a standard two-phase APB transfer (SETUP, then ACCESS with wait states) and returns read data and error to the winner. It sits between the requester blocks and the register slave's APB port.

---
 rtl/apb_reg_arbiter_pkg.sv | 28 ++
 rtl/apb_reg_arbiter_rr_arbiter.sv | 50 +++++
 rtl/apb_reg_arbiter.sv | 165 ++++++++++++++++
 tb/tb_apb_reg_arbiter.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_reg_arbiter_pkg.sv
// Shared types and constants for the APB register arbiter.
// The optional ACCESS timeout is compiled in with APB_ARB_TIMEOUT_EN.
package apb_reg_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  // One-hot register selects understood by the slave.
  localparam logic [7:0] REG_A = 8'h01;
  localparam logic [7:0] REG_B = 8'h02;
  localparam logic [7:0] REG_C = 8'h04;
  localparam logic [7:0] REG_D = 8'h08;
  localparam logic [7:0] REG_E = 8'h10;
  localparam logic [7:0] REG_F = 8'h20;
  localparam logic [7:0] REG_G = 8'h40;
  localparam logic [7:0] REG_H = 8'h80;

  localparam int TIMEOUT_CYCLES_DEFAULT = 16;

  // True when exactly one bit of the register select is set.
  function automatic logic is_one_hot(input logic [7:0] addr);
    return (addr != 8'h00) && ((addr & (addr - 8'h01)) == 8'h00);
  endfunction

endpackage

// File: rtl/apb_reg_arbiter_rr_arbiter.sv
// Round-robin arbiter: picks the first active request at or after the
// pointer, and moves the pointer just past the winner whenever it grants.
module rr_arbiter #(
  parameter int NUM_REQ = 2
) (
  input  logic                       pclk,
  input  logic                       preset_n,
  input  logic [NUM_REQ-1:0]         req,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] grant_idx
);

  localparam int IDXW = $clog2(NUM_REQ);

  logic [IDXW-1:0] ptr_reg;
  logic [IDXW-1:0] cand;
  int              cand_int;
  logic            found;

  // Search the request vector starting at the pointer, wrapping once.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = '0;
    cand_int  = 0;
    for (int off = 0; off < NUM_REQ; off++) begin
      cand_int = int'(ptr_reg) + off;
      if (cand_int >= NUM_REQ) begin
        cand_int = cand_int - NUM_REQ;
      end
      cand = IDXW'(cand_int);
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // Advance the pointer to the requester after the winner on every grant.
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      ptr_reg <= '0;
    end else if (|req) begin
      ptr_reg <= (grant_idx == IDXW'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/apb_reg_arbiter.sv
// Arbitrating APB master sharing the 8-register slave between NUM_REQ
// requesters. Define APB_ARB_TIMEOUT_EN to bound ACCESS wait states to
// TIMEOUT_CYCLES; otherwise ACCESS waits for pready indefinitely.
// State and APB outputs are both registered, so the bus phase lags the
// FSM state by one cycle: psel rises on the edge leaving SETUP and
// penable on the first edge spent in ACCESS.
module apb_reg_arbiter
  import apb_reg_arbiter_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic                 pclk,
  input  logic                 preset_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ-1:0]   req_write,
  input  logic [8*NUM_REQ-1:0] req_addr,
  input  logic [8*NUM_REQ-1:0] req_wdata,
  output logic [NUM_REQ-1:0]   req_done,
  output logic [7:0]           req_rdata,
  output logic                 req_err,
  output logic                 psel,
  output logic                 penable,
  output logic                 pwrite,
  output logic [7:0]           paddr,
  output logic [7:0]           pwdata,
  input  logic [7:0]           prdata,
  input  logic                 pready,
  input  logic                 psvlerr
);

  localparam int IDXW = $clog2(NUM_REQ);

  state_t              state_reg;
  logic [IDXW-1:0]     gidx_reg;
  logic                legal_reg;
  logic                write_reg;
  logic [7:0]          addr_reg;
  logic [7:0]          wdata_reg;

  logic [NUM_REQ-1:0]  arb_req;
  logic [NUM_REQ-1:0]  arb_grant;
  logic [IDXW-1:0]     arb_idx;
  logic                sel_write;
  logic [7:0]          sel_addr;
  logic [7:0]          sel_wdata;
  logic [NUM_REQ-1:0]  g_onehot;

`ifdef APB_ARB_TIMEOUT_EN
  localparam int TOW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TOW-1:0] to_cnt_reg;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES > 0);
`endif

  // Only arbitrate in IDLE; a requester completing this cycle sits out.
  assign arb_req = (state_reg == IDLE) ? (req_valid & ~req_done) : '0;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .pclk      (pclk),
    .preset_n  (preset_n),
    .req       (arb_req),
    .grant     (arb_grant),
    .grant_idx (arb_idx)
  );

  // Pick the winner's request fields and build the done mask for the latched grant.
  always_comb begin
    sel_write = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    g_onehot  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_grant[i]) begin
        sel_write = req_write[i];
        sel_addr  = req_addr[i*8 +: 8];
        sel_wdata = req_wdata[i*8 +: 8];
      end
    end
    g_onehot[gidx_reg] = 1'b1;
  end

  // Transfer FSM with registered APB and requester-side outputs.
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      state_reg  <= IDLE;
      gidx_reg   <= '0;
      legal_reg  <= 1'b0;
      write_reg  <= 1'b0;
      addr_reg   <= '0;
      wdata_reg  <= '0;
      psel       <= 1'b0;
      penable    <= 1'b0;
      pwrite     <= 1'b0;
      paddr      <= '0;
      pwdata     <= '0;
      req_done   <= '0;
      req_rdata  <= '0;
      req_err    <= 1'b0;
`ifdef APB_ARB_TIMEOUT_EN
      to_cnt_reg <= '0;
`endif
    end else begin
      req_done <= '0;
      case (state_reg)
        IDLE: begin
          if (|arb_req) begin
            gidx_reg   <= arb_idx;
            write_reg  <= sel_write;
            addr_reg   <= sel_addr;
            wdata_reg  <= sel_wdata;
            legal_reg  <= is_one_hot(sel_addr);
`ifdef APB_ARB_TIMEOUT_EN
            to_cnt_reg <= '0;
`endif
            state_reg  <= SETUP;
          end
        end
        SETUP: begin
          if (legal_reg) begin
            psel      <= 1'b1;
            penable   <= 1'b0;
            paddr     <= addr_reg;
            pwrite    <= write_reg;
            pwdata    <= wdata_reg;
            state_reg <= ACCESS;
          end else begin
            // Malformed select: answer with an error without touching the bus.
            req_done  <= g_onehot;
            req_err   <= 1'b1;
            req_rdata <= '0;
            state_reg <= IDLE;
          end
        end
        ACCESS: begin
          if (!penable) begin
            penable <= 1'b1;
          end else if (pready) begin
            psel      <= 1'b0;
            penable   <= 1'b0;
            req_done  <= g_onehot;
            req_rdata <= write_reg ? 8'h00 : prdata;
            req_err   <= psvlerr;
            state_reg <= IDLE;
          end
`ifdef APB_ARB_TIMEOUT_EN
          else if (to_cnt_reg == TOW'(TIMEOUT_CYCLES - 1)) begin
            psel      <= 1'b0;
            penable   <= 1'b0;
            req_done  <= g_onehot;
            req_rdata <= '0;
            req_err   <= 1'b1;
            state_reg <= IDLE;
          end else begin
            to_cnt_reg <= to_cnt_reg + 1'b1;
          end
`endif
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_reg_arbiter.sv
// Directed bench for apb_reg_arbiter with a simple 8-register APB slave
// model. Timeout checks run only when APB_ARB_TIMEOUT_EN is defined.
module tb_apb_reg_arbiter;
  import apb_reg_arbiter_pkg::*;

  localparam int NR = 2;

  logic            pclk = 1'b0;
  logic            preset_n = 1'b0;
  logic [NR-1:0]   req_valid = '0;
  logic [NR-1:0]   req_write = '0;
  logic [8*NR-1:0] req_addr = '0;
  logic [8*NR-1:0] req_wdata = '0;
  logic [NR-1:0]   req_done;
  logic [7:0]      req_rdata;
  logic            req_err;
  logic            psel, penable, pwrite;
  logic [7:0]      paddr, pwdata, prdata;
  logic            pready, psvlerr;

  always #5 pclk = ~pclk;

  apb_reg_arbiter #(.NUM_REQ(NR), .TIMEOUT_CYCLES(4)) dut (
    .pclk(pclk), .preset_n(preset_n),
    .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .req_done(req_done), .req_rdata(req_rdata), .req_err(req_err),
    .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata),
    .pready(pready), .psvlerr(psvlerr)
  );

  // ---------------- slave model ----------------
  int         wait_cfg = 0;
  logic       slv_err = 1'b0;
  int         wait_cnt;
  logic [7:0] mem [8];

  function automatic int oh_idx(input logic [7:0] a);
    for (int i = 0; i < 8; i++) if (a[i]) return i;
    return 0;
  endfunction

  assign pready  = psel && penable && (wait_cnt >= wait_cfg);
  assign psvlerr = slv_err && pready;
  assign prdata  = mem[oh_idx(paddr)];

  always @(posedge pclk) begin
    if (!preset_n) begin
      wait_cnt <= 0;
      for (int i = 0; i < 8; i++) mem[i] <= 8'h00;
    end else begin
      if (psel && penable && !pready) wait_cnt <= wait_cnt + 1;
      else wait_cnt <= 0;
      if (psel && penable && pready && pwrite) mem[oh_idx(paddr)] <= pwdata;
    end
  end

  // ---------------- bus monitor ----------------
  int         psel_cnt = 0, pen_cnt = 0, stab_bad = 0;
  logic [7:0] exp_paddr = '0, exp_pwdata = '0;
  logic       exp_pwrite = 1'b0;
  bit         mon_chk = 1'b0;

  always @(negedge pclk) begin
    if (psel) psel_cnt++;
    if (penable) pen_cnt++;
    if (psel && mon_chk &&
        (paddr !== exp_paddr || pwdata !== exp_pwdata || pwrite !== exp_pwrite))
      stab_bad++;
  end

  // ---------------- checking ----------------
  int checks = 0, errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic wait_done(input int r, input int max_cyc, output int got,
                           output logic [NR-1:0] dv, output logic [7:0] rd, output logic er);
    got = 0; dv = '0; rd = '0; er = 1'b0;
    for (int c = 0; c < max_cyc; c++) begin
      @(negedge pclk);
      if (req_done != '0) begin
        got = 1; dv = req_done; rd = req_rdata; er = req_err;
        req_valid[r] = 1'b0;
        break;
      end
    end
    if (got == 0) req_valid[r] = 1'b0;
  endtask

  typedef struct {
    int         r;
    logic       wr;
    logic [7:0] addr;
    logic [7:0] wdata;
    int         wt;
    logic       serr;
    logic [7:0] exp_rd;
    logic       exp_err;
    int         exp_psel;
  } vec_t;

  localparam int NV = 16;
  vec_t vecs [NV];

  initial begin
    vec_t            vec;
    int              got, ps0, pe0, sb0, n, dcount;
    logic [NR-1:0]   dv, ed;
    logic [7:0]      rd;
    logic            er;

    //           r  wr    addr   wdata  wt serr exp_rd exp_err psel
    vecs[0]  = '{0, 1'b1, REG_C, 8'h5A, 0, 1'b0, 8'h00, 1'b0, 2};
    vecs[1]  = '{0, 1'b0, REG_C, 8'h00, 0, 1'b0, 8'h5A, 1'b0, 2};
    vecs[2]  = '{1, 1'b1, REG_H, 8'hC3, 3, 1'b0, 8'h00, 1'b0, 5};
    vecs[3]  = '{1, 1'b0, REG_H, 8'h00, 1, 1'b0, 8'hC3, 1'b0, 3};
    vecs[4]  = '{0, 1'b1, 8'h03, 8'h77, 0, 1'b0, 8'h00, 1'b1, 0};
    vecs[5]  = '{1, 1'b0, 8'h00, 8'h00, 0, 1'b0, 8'h00, 1'b1, 0};
    vecs[6]  = '{0, 1'b1, REG_A, 8'hA5, 0, 1'b0, 8'h00, 1'b0, 2};
    vecs[7]  = '{1, 1'b0, REG_A, 8'h00, 2, 1'b0, 8'hA5, 1'b0, 4};
    vecs[8]  = '{0, 1'b0, REG_H, 8'h00, 0, 1'b1, 8'hC3, 1'b1, 2};
    vecs[9]  = '{1, 1'b1, REG_B, 8'h3C, 0, 1'b1, 8'h00, 1'b1, 2};
    vecs[10] = '{0, 1'b0, REG_B, 8'h00, 0, 1'b0, 8'h3C, 1'b0, 2};
    vecs[11] = '{1, 1'b1, REG_D, 8'h0F, 0, 1'b0, 8'h00, 1'b0, 2};
    vecs[12] = '{0, 1'b1, REG_E, 8'hF0, 0, 1'b0, 8'h00, 1'b0, 2};
    vecs[13] = '{1, 1'b1, REG_F, 8'h11, 0, 1'b0, 8'h00, 1'b0, 2};
    vecs[14] = '{0, 1'b0, REG_D, 8'h00, 0, 1'b0, 8'h0F, 1'b0, 2};
    vecs[15] = '{1, 1'b0, REG_F, 8'h00, 4, 1'b0, 8'h11, 1'b0, 6};

    // Reset state
    @(negedge pclk); @(negedge pclk);
    chk("reset_outputs", int'({psel, penable, pwrite, paddr, pwdata, req_done, req_rdata, req_err}), 0);
    @(negedge pclk);
    preset_n = 1'b1;

    // Table-driven transfers
    for (int v = 0; v < NV; v++) begin
      vec = vecs[v];
      wait_cfg = vec.wt; slv_err = vec.serr;
      exp_paddr = vec.addr; exp_pwdata = vec.wdata; exp_pwrite = vec.wr; mon_chk = 1'b1;
      ps0 = psel_cnt; pe0 = pen_cnt; sb0 = stab_bad;
      @(posedge pclk); #1;
      req_valid[vec.r] = 1'b1;
      req_write[vec.r] = vec.wr;
      req_addr[vec.r*8 +: 8] = vec.addr;
      req_wdata[vec.r*8 +: 8] = vec.wdata;
      wait_done(vec.r, 50, got, dv, rd, er);
      #1;
      ed = '0; ed[vec.r] = 1'b1;
      $display("txn %0d: req=%0d wr=%0b addr=%h wdata=%h -> done=%b rdata=%h err=%0b psel_cyc=%0d",
               v, vec.r, vec.wr, vec.addr, vec.wdata, dv, rd, er, psel_cnt - ps0);
      chk($sformatf("v%0d_done_seen", v), got, 1);
      chk($sformatf("v%0d_done_vec", v), int'(dv), int'(ed));
      chk($sformatf("v%0d_rdata", v), int'(rd), int'(vec.exp_rd));
      chk($sformatf("v%0d_err", v), int'(er), int'(vec.exp_err));
      chk($sformatf("v%0d_psel_cycles", v), psel_cnt - ps0, vec.exp_psel);
      chk($sformatf("v%0d_penable_cycles", v), pen_cnt - pe0, (vec.exp_psel > 0) ? vec.exp_psel - 1 : 0);
      chk($sformatf("v%0d_bus_stable", v), stab_bad - sb0, 0);
    end
    mon_chk = 1'b0; slv_err = 1'b0;

`ifdef APB_ARB_TIMEOUT_EN
    // Timeout: pready never arrives within the limit
    wait_cfg = 1000;
    pe0 = pen_cnt;
    @(posedge pclk); #1;
    req_valid[1] = 1'b1; req_write[1] = 1'b0; req_addr[15:8] = REG_A;
    wait_done(1, 50, got, dv, rd, er);
    #1;
    $display("txn timeout: req=1 -> done=%b rdata=%h err=%0b penable_cyc=%0d", dv, rd, er, pen_cnt - pe0);
    chk("to_done_seen", got, 1);
    chk("to_err", int'(er), 1);
    chk("to_rdata", int'(rd), 0);
    chk("to_penable_cycles", pen_cnt - pe0, 4);
    wait_cfg = 0;
`endif

    // Reset pulsed during ACCESS
    wait_cfg = 20;
    @(posedge pclk); #1;
    req_valid[0] = 1'b1; req_write[0] = 1'b0; req_addr[7:0] = REG_C;
    got = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge pclk);
      if (penable) begin got = 1; break; end
    end
    chk("rst_reached_access", got, 1);
    @(negedge pclk); @(negedge pclk);
    preset_n = 1'b0;
    #1;
    chk("rst_mid_outputs", int'({psel, penable, pwrite, paddr, pwdata, req_done, req_rdata, req_err}), 0);
    req_valid = '0;
    @(negedge pclk); @(negedge pclk);
    preset_n = 1'b1; wait_cfg = 0;
    dcount = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge pclk);
      if (req_done != '0) dcount++;
    end
    chk("rst_no_done", dcount, 0);
    $display("txn reset_abort: done pulses after release=%0d", dcount);

    // Both requesters continuously valid: grants alternate starting at 0
    @(posedge pclk); #1;
    req_write = 2'b11;
    req_addr = {REG_G, REG_B};
    req_wdata = {8'h22, 8'h11};
    req_valid = 2'b11;
    n = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge pclk);
      if (req_done != '0) begin
        if (n == 3) req_valid = '0;
        $display("txn rr%0d: done=%b", n, req_done);
        chk($sformatf("rr%0d_onehot", n), $countones(req_done), 1);
        chk($sformatf("rr%0d_grant", n), int'(req_done[1]), n % 2);
        n++;
        if (n == 4) break;
      end
    end
    req_valid = '0;
    chk("rr_count", n, 4);

    repeat (3) @(negedge pclk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global guard against a hung run
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
